// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC Wishbone reader: register offsets,
// CTRL/STATUS bit positions and the conversion sequencer state type.
package sar_pkg;

  // Byte offsets from BASE_ADDR; decode uses bits [3:2]
  localparam logic [3:0] SAR_REG_CTRL   = 4'h0;
  localparam logic [3:0] SAR_REG_STATUS = 4'h4;
  localparam logic [3:0] SAR_REG_DATA   = 4'h8;

  // CTRL fields
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_CONT_BIT   = 1;
  localparam int CTRL_THRESH_LSB = 4;
  localparam int CTRL_THRESH_W   = 4;

  // STATUS fields
  localparam int STATUS_COUNT_W   = 4;
  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_FULL_BIT  = 9;
  localparam int STATUS_OVF_BIT   = 10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sar_rd_state_t;

endpackage

// File: rtl/sar_result_fifo.sv
// Result FIFO for finished SAR conversions. A push while full is dropped and
// flagged on ovf_pulse, unless a pop happens in the same cycle, in which case
// both proceed. A pop while empty is ignored.
module sar_result_fifo
  import sar_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_W-1:0]               din,
  output logic [DATA_W-1:0]               dout,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            full,
  output logic                            empty,
  output logic                            ovf_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == CW'(FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || pop);
  assign ovf_pulse = push && full && !pop;
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];

  // Storage array write
  // NOTE: the data array has no reset; only the pointers and count define
  // which entries are meaningful, so clearing the storage buys nothing.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at FIFO_DEPTH
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sar_wb_reader.sv
// Wishbone slave that starts SAR conversions and buffers their results.
// Registers: CTRL (START/CONT), STATUS (count/empty/full/OVF W1C), DATA (pop).
// Optional macro SAR_WB_READER_IRQ_EN adds CTRL[7:4] THRESH and the irq output.
module sar_wb_reader
  import sar_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          DATA_W     = 10,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              conv_start,
  input  logic              conv_busy,
  input  logic              result_valid,
`ifdef SAR_WB_READER_IRQ_EN
  output logic              irq,
`endif
  input  logic [DATA_W-1:0] result_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_cont;
  logic              r_ovf;
  logic              r_conv_start;
  sar_rd_state_t     r_state;

  logic              w_hit;
  logic              w_valid;
  logic              w_wr;
  logic              w_rd;
  logic              w_sel_ctrl;
  logic              w_sel_status;
  logic              w_sel_data;
  logic              w_start_wr;
  logic              w_ovf_clr;
  logic              w_pop;
  logic [DATA_W-1:0] w_dout;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_pulse;
  logic [31:0]       w_cnt_ext;
  logic [31:0]       w_status;
  logic [31:0]       w_ctrl;
  logic [31:0]       w_rd_data;
  logic              w_unused;

  // Bus decode: one access per ack, so a held strobe acks every other cycle
  assign w_hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_valid      = wbs_cyc_i && wbs_stb_i && w_hit && !r_ack;
  assign w_wr         = w_valid && wbs_we_i && wbs_sel_i[0];
  assign w_rd         = w_valid && !wbs_we_i;
  assign w_sel_ctrl   = (wbs_adr_i[3:2] == SAR_REG_CTRL[3:2]);
  assign w_sel_status = (wbs_adr_i[3:2] == SAR_REG_STATUS[3:2]);
  assign w_sel_data   = (wbs_adr_i[3:2] == SAR_REG_DATA[3:2]);

  // Side-effect strobes, each fired once at the edge that raises the ack
  assign w_start_wr = w_wr && w_sel_ctrl && wbs_dat_i[CTRL_START_BIT];
  assign w_ovf_clr  = w_wr && w_sel_status && wbs_dat_i[STATUS_OVF_BIT];
  assign w_pop      = w_rd && w_sel_data && !w_empty;

  assign w_cnt_ext  = 32'(w_count);
  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign conv_start = r_conv_start;

  // Bits of the bus that have no function in this register map
  assign w_unused = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:11], wbs_dat_i[9:2],
                      wbs_adr_i[1:0], w_cnt_ext[31:STATUS_COUNT_W]};

  sar_result_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (result_valid),
    .pop       (w_pop),
    .din       (result_data),
    .dout      (w_dout),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty),
    .ovf_pulse (w_ovf_pulse)
  );

`ifdef SAR_WB_READER_IRQ_EN
  logic [CTRL_THRESH_W-1:0] r_thresh;
  logic                     r_irq;

  assign irq = r_irq;

  // Interrupt: occupancy at/above a non-zero threshold, or any overflow
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= ((r_thresh != '0) && (w_cnt_ext >= 32'(r_thresh))) || r_ovf;
    end
  end
`endif

  // Register read views
  // NOTE: every combinational output gets a default before the case/field
  // assignments so no path leaves a value held, which would infer a latch.
  always_comb begin
    w_status = '0;
    w_status[STATUS_COUNT_W-1:0] = w_cnt_ext[STATUS_COUNT_W-1:0];
    w_status[STATUS_EMPTY_BIT]   = w_empty;
    w_status[STATUS_FULL_BIT]    = w_full;
    w_status[STATUS_OVF_BIT]     = r_ovf;

    w_ctrl = '0;
    w_ctrl[CTRL_CONT_BIT] = r_cont;
`ifdef SAR_WB_READER_IRQ_EN
    w_ctrl[CTRL_THRESH_LSB +: CTRL_THRESH_W] = r_thresh;
`endif

    w_rd_data = '0;
    if (w_sel_ctrl) begin
      w_rd_data = w_ctrl;
    end else if (w_sel_status) begin
      w_rd_data = w_status;
    end else if (w_sel_data && !w_empty) begin
      w_rd_data = 32'(w_dout);
    end
  end

  // Wishbone ack and read data, both registered; data is zero outside an ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_valid;
      r_dat <= w_rd ? w_rd_data : '0;
    end
  end

  // CTRL storage; START is not stored, it only feeds the sequencer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cont <= 1'b0;
`ifdef SAR_WB_READER_IRQ_EN
      r_thresh <= '0;
`endif
    end else if (w_wr && w_sel_ctrl) begin
      r_cont <= wbs_dat_i[CTRL_CONT_BIT];
`ifdef SAR_WB_READER_IRQ_EN
      r_thresh <= wbs_dat_i[CTRL_THRESH_LSB +: CTRL_THRESH_W];
`endif
    end
  end

  // Sticky overflow flag; a new overflow wins over a same-cycle clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_pulse) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Conversion sequencer: one request in flight, conv_start pulses on launch
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_conv_start <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((w_start_wr || (r_cont && !w_full)) && !conv_busy) begin
            r_state      <= WAIT;
            r_conv_start <= 1'b1;
          end
        end
        WAIT: begin
          if (result_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_wb_reader.sv
// Self-checking bench for sar_wb_reader: Wishbone register access, single and
// continuous conversions, FIFO full/empty corner cases, reset mid-operation,
// and the optional irq (build with SAR_WB_READER_IRQ_EN).
module tb_sar_wb_reader;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] O_CTRL = 32'h0;
  localparam logic [31:0] O_STAT = 32'h4;
  localparam logic [31:0] O_DATA = 32'h8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        conv_start;
  logic        conv_busy;
  logic        result_valid;
  logic [9:0]  result_data;
`ifdef SAR_WB_READER_IRQ_EN
  logic        irq;
`endif

  // Bench-side SAR model and manual injection share the result bus
  logic        model_rv = 1'b0;
  logic        model_busy = 1'b0;
  logic [9:0]  model_data = '0;
  logic [9:0]  next_val = 10'h2A5;
  logic        force_rv = 1'b0;
  logic [9:0]  force_data = '0;

  assign result_valid = model_rv | force_rv;
  assign result_data  = force_rv ? force_data : model_data;
  assign conv_busy    = model_busy;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_start_cycles = 0;
  logic [9:0]  exp_q [$];

  always #5 wb_clk_i = ~wb_clk_i;

  sar_wb_reader dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .conv_start   (conv_start),
    .conv_busy    (conv_busy),
    .result_valid (result_valid),
`ifdef SAR_WB_READER_IRQ_EN
    .irq          (irq),
`endif
    .result_data  (result_data)
  );

  // Count every cycle conv_start is high
  initial forever begin
    @(negedge wb_clk_i);
    if (conv_start === 1'b1) n_start_cycles++;
  end

  // SAR model: busy for 12 cycles after a request, then one result strobe.
  // The expected value enters the scoreboard unless the FIFO is already full.
  initial forever begin
    @(negedge wb_clk_i);
    if (conv_start === 1'b1) begin
      model_busy = 1'b1;
      repeat (12) @(negedge wb_clk_i);
      model_data = next_val;
      next_val   = next_val + 10'h13;
      model_rv   = 1'b1;
      if (exp_q.size() < 8) exp_q.push_back(model_data);
      @(negedge wb_clk_i);
      model_rv   = 1'b0;
      model_busy = 1'b0;
    end
  end

  // One Wishbone access; lat = cycles until ack, -1 if none within 8 cycles
  task automatic wb_cycle(input logic we, input logic [31:0] off,
                          input logic [31:0] wdat, output logic [31:0] rdat,
                          output int lat);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = BASE + off; wbs_dat_i = wdat;
    lat = -1;
    rdat = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o === 1'b1) begin
        lat  = i;
        rdat = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  // Inject one result strobe directly on the bus
  task automatic inject(input logic [9:0] val, input logic expect_push);
    @(negedge wb_clk_i);
    force_rv = 1'b1; force_data = val;
    if (expect_push) exp_q.push_back(val);
    @(negedge wb_clk_i);
    force_rv = 1'b0;
  endtask

  task automatic wait_q(input int n, input string name);
    int waited = 0;
    while (exp_q.size() != n && waited < 500) begin
      @(negedge wb_clk_i);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != n) begin
      n_fail++;
      $display("FAIL %s: scoreboard depth %0d, required %0d (timeout)", name, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r; int lat;
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    n_checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || conv_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b dat=%h conv_start=%b, required 0/0/0", wbs_ack_o, wbs_dat_o, conv_start);
    end
    wb_rst_i = 1'b0;
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL reset_ack_latency: got %0d, required 1", lat); end
    n_checks++;
    if (r !== 32'h100) begin n_fail++; $display("FAIL reset_status: got %h, required 00000100", r); end
    @(negedge wb_clk_i);
    n_checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_post_ack: ack=%b dat=%h, required 0/0", wbs_ack_o, wbs_dat_o);
    end
  endtask

  task automatic test_single_conv();
    logic [31:0] r; int lat;
    n_start_cycles = 0;
    wb_cycle(1'b1, O_CTRL, 32'h1, r, lat);
    wait_q(1, "single_result_arrival");
    repeat (2) @(negedge wb_clk_i);
    n_checks++;
    if (n_start_cycles !== 1) begin n_fail++; $display("FAIL single_conv_start: %0d pulse cycles, required 1", n_start_cycles); end
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h001) begin n_fail++; $display("FAIL single_status: got %h, required 00000001", r); end
    wb_cycle(1'b0, O_CTRL, '0, r, lat);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL ctrl_start_reads0: got %h, required 00000000", r); end
    wb_cycle(1'b0, O_DATA, '0, r, lat);
    n_checks++;
    if (r !== 32'h2A5 || exp_q.size() == 0 || exp_q.pop_front() !== 10'h2A5) begin
      n_fail++; $display("FAIL single_data: got %h, required 000002a5", r);
    end
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h100) begin n_fail++; $display("FAIL single_status_after_pop: got %h, required 00000100", r); end
  endtask

  task automatic test_cont_overflow();
    logic [31:0] r; int lat;
    n_start_cycles = 0;
    wb_cycle(1'b1, O_CTRL, 32'h2, r, lat);
    wait_q(8, "cont_fill");
    repeat (40) @(negedge wb_clk_i);
    n_checks++;
    if (n_start_cycles !== 8) begin n_fail++; $display("FAIL cont_starts: %0d pulse cycles, required 8", n_start_cycles); end
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h208) begin n_fail++; $display("FAIL cont_full_status: got %h, required 00000208", r); end
    wb_cycle(1'b1, O_CTRL, 32'h0, r, lat);
    inject(10'h155, 1'b0);
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h608) begin n_fail++; $display("FAIL ovf_status: got %h, required 00000608", r); end
    wb_cycle(1'b1, O_STAT, 32'h400, r, lat);
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h208) begin n_fail++; $display("FAIL ovf_w1c: got %h, required 00000208", r); end
  endtask

  // DATA read whose ack-raising edge coincides with a result strobe
  task automatic coincident_read(input logic [9:0] val, output logic [31:0] rdat,
                                 output logic [31:0] expd);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + O_DATA;
    force_rv = 1'b1; force_data = val;
    expd = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h0;
    exp_q.push_back(val);
    @(negedge wb_clk_i);
    force_rv = 1'b0;
    rdat = (wbs_ack_o === 1'b1) ? wbs_dat_o : 32'hDEAD_BEEF;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic test_full_pop_push();
    logic [31:0] r, e; int lat;
    coincident_read(10'h3FF, r, e);
    n_checks++;
    if (r !== e) begin n_fail++; $display("FAIL full_pop_push_data: got %h, required %h", r, e); end
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h208) begin n_fail++; $display("FAIL full_pop_push_status: got %h, required 00000208", r); end
    for (int i = 0; i < 8; i++) begin
      e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
      wb_cycle(1'b0, O_DATA, '0, r, lat);
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL drain_%0d: got %h, required %h", i, r, e); end
      if (i == 7) begin
        n_checks++;
        if (r !== 32'h3FF) begin n_fail++; $display("FAIL last_entry: got %h, required 000003ff", r); end
      end
    end
    wb_cycle(1'b0, O_DATA, '0, r, lat);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL empty_read: got %h, required 00000000", r); end
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h100) begin n_fail++; $display("FAIL drained_status: got %h, required 00000100", r); end
  endtask

  task automatic test_empty_pop_push();
    logic [31:0] r, e; int lat;
    coincident_read(10'h0C3, r, e);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL empty_pop_push_data: got %h, required 00000000", r); end
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h001) begin n_fail++; $display("FAIL empty_pop_push_status: got %h, required 00000001", r); end
    e = 32'(exp_q.pop_front());
    wb_cycle(1'b0, O_DATA, '0, r, lat);
    n_checks++;
    if (r !== e) begin n_fail++; $display("FAIL empty_pop_push_entry: got %h, required %h", r, e); end
  endtask

  task automatic test_unmapped();
    logic [31:0] r; int lat;
    wb_cycle(1'b1, 32'hC, 32'hFFFF_FFFF, r, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL unmapped_write_ack: latency %0d, required 1", lat); end
    wb_cycle(1'b0, 32'hC, '0, r, lat);
    n_checks++;
    if (lat !== 1 || r !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: lat %0d data %h, required 1/00000000", lat, r); end
    wb_cycle(1'b0, 32'h10, '0, r, lat);
    n_checks++;
    if (lat !== -1) begin n_fail++; $display("FAIL out_of_range_ack: latency %0d, required no ack", lat); end
    wb_cycle(1'b1, O_CTRL, 32'hF0, r, lat);
    wb_cycle(1'b0, O_CTRL, '0, r, lat);
    n_checks++;
`ifdef SAR_WB_READER_IRQ_EN
    if (r !== 32'hF0) begin n_fail++; $display("FAIL ctrl_thresh_rw: got %h, required 000000f0", r); end
`else
    if (r !== 32'h0) begin n_fail++; $display("FAIL ctrl_thresh_absent: got %h, required 00000000", r); end
`endif
    wb_cycle(1'b1, O_CTRL, 32'h0, r, lat);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + O_STAT;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      n_checks++;
      if (wbs_ack_o !== ((i % 2) == 0) || wbs_dat_o !== (((i % 2) == 0) ? 32'h100 : 32'h0)) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: ack=%b dat=%h, required ack=%0d", i, wbs_ack_o, wbs_dat_o, (i % 2) == 0);
      end
      if (wbs_ack_o === 1'b1) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    n_checks++;
    if (acks !== 3) begin n_fail++; $display("FAIL back_to_back_count: %0d acks, required 3", acks); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, e; int lat;
    wb_cycle(1'b1, O_CTRL, 32'h1, r, lat);
    repeat (3) @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + O_STAT;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    n_checks++;
    if (wbs_ack_o !== 1'b0 || conv_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_ack: ack=%b conv_start=%b, required 0/0", wbs_ack_o, conv_start);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    exp_q.delete();
    @(negedge wb_clk_i);
    n_checks++;
    if (wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_late_ack: ack=%b, required 0", wbs_ack_o); end
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h100) begin n_fail++; $display("FAIL reset_mid_status: got %h, required 00000100", r); end
    wait_q(1, "late_result_arrival");
    repeat (2) @(negedge wb_clk_i);
    wb_cycle(1'b0, O_STAT, '0, r, lat);
    n_checks++;
    if (r !== 32'h001) begin n_fail++; $display("FAIL late_result_status: got %h, required 00000001", r); end
    e = 32'(exp_q.pop_front());
    wb_cycle(1'b0, O_DATA, '0, r, lat);
    n_checks++;
    if (r !== e) begin n_fail++; $display("FAIL late_result_data: got %h, required %h", r, e); end
  endtask

`ifdef SAR_WB_READER_IRQ_EN
  task automatic test_irq();
    logic [31:0] r, e; int lat;
    wb_cycle(1'b1, O_CTRL, 32'h30, r, lat);
    inject(10'h011, 1'b1);
    inject(10'h022, 1'b1);
    inject(10'h033, 1'b1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b, required 0", irq); end
    @(negedge wb_clk_i);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b, required 1", irq); end
    e = 32'(exp_q.pop_front());
    wb_cycle(1'b0, O_DATA, '0, r, lat);
    n_checks++;
    if (r !== e) begin n_fail++; $display("FAIL irq_pop_data: got %h, required %h", r, e); end
    @(negedge wb_clk_i);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b, required 0", irq); end
    for (int i = 0; i < 2; i++) begin
      e = 32'(exp_q.pop_front());
      wb_cycle(1'b0, O_DATA, '0, r, lat);
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL irq_drain_%0d: got %h, required %h", i, r, e); end
    end
    wb_cycle(1'b1, O_CTRL, 32'h0, r, lat);
  endtask
`endif

  initial begin
    test_reset();
    test_single_conv();
    test_back_to_back();
    test_unmapped();
    test_cont_overflow();
    test_full_pop_push();
    test_empty_pop_push();
    test_reset_mid();
`ifdef SAR_WB_READER_IRQ_EN
    test_irq();
`endif
    repeat (4) @(negedge wb_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_wb_reader.md
Name: sar_wb_reader

Overview:
- Wishbone slave on the management SoC bus; the host-side reader for the SAR ADC.
- Issues conversion-start requests to the SAR conversion logic.
- Captures each finished conversion result into a small FIFO.
- Lets firmware read results and status through three memory-mapped registers.
- Sits in user_project_wrapper beside the SAR logic, on the wbs_* port group.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of register 0; decode on wbs_adr_i[31:4].
- DATA_W, 10, SAR result width in bits.
- FIFO_DEPTH, 8, result FIFO entries; must be a power of two, at least 2.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; only sel[0] is honoured for writes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- conv_start  out  1  one-cycle pulse that requests one conversion.
- conv_busy  in  1  high while the SAR logic is converting.
- result_valid  in  1  one-cycle strobe marking result_data as valid.
- result_data  in  DATA_W  conversion result.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 CTRL (R/W): bit0 START, write-1 self-clearing, reads 0; bit1 CONT, continuous-mode enable.
  - 0x4 STATUS (R/W1C): [3:0] count; bit8 empty; bit9 full; bit10 OVF, sticky, write 1 to clear.
  - 0x8 DATA (RO): [DATA_W-1:0] FIFO head; a read pops the entry. Reading when empty returns 0 and does not pop.
  - 0xC and unmapped in-range offsets: read 0, writes ignored, still acked.
- Bus handshake:
  - Access is valid when cyc & stb & address hit & !ack.
  - wbs_ack_o goes high exactly 1 cycle after a valid access, for exactly 1 cycle.
  - Back-to-back accesses therefore ack every second cycle.
  - wbs_dat_o is registered with the ack and is 0 when ack is low.
  - Register side effects (pop, W1C, START) take effect on the ack cycle only, once per access.
- Conversion sequencing:
  - Two-state FSM, IDLE and WAIT.
  - IDLE to WAIT: START is written, or CONT=1 and FIFO not full, and conv_busy=0. conv_start pulses for 1 cycle on that transition.
  - WAIT to IDLE: on result_valid.
  - START written while in WAIT is ignored.
  - A result_valid that arrives in IDLE is still captured; the FIFO does not check FSM state.
- FIFO:
  - Push on result_valid. Push while full drops the new sample and sets OVF.
  - Simultaneous push and pop when full: both succeed; count is unchanged; OVF is not set.
  - Simultaneous push and pop when empty: push only; the read returns 0.
  - Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[3:0].
  - Result data is zero-extended to 32 bits.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, conv_start=0, CTRL=0, FIFO empty, OVF=0, FSM=IDLE.
  - Reset in mid-transaction drops the pending ack.
  - Reset during WAIT returns the FSM to IDLE; a late result_valid after reset is pushed normally.

Optional Feature:
- Macro: SAR_WB_READER_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and CTRL[7:4] THRESH.
  - irq is registered and high while count >= THRESH and THRESH != 0, or while OVF=1.
  - irq resets to 0. Intended wiring: user_irq[0].
- Not defined: no irq port; CTRL[7:4] read 0 and ignore writes.

Decomposition:
- Package sar_pkg:
  - Register offset constants: SAR_REG_CTRL, SAR_REG_STATUS, SAR_REG_DATA.
  - STATUS and CTRL bit-position constants.
  - FSM state enum sar_rd_state_t {IDLE, WAIT}.
- One sub-module: sar_result_fifo.
  - Parameters DATA_W and FIFO_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty, ovf_pulse.
  - Synchronous reset.

Test Plan:
- Reset, then read STATUS: data 0x100 (empty), ack exactly 1 cycle after stb; wbs_dat_o=0 outside the ack.
- Write CTRL=0x1, model returns result 10'h2A5 after 12 cycles: conv_start pulses once; STATUS=0x001; DATA read returns 0x2A5; STATUS returns 0x100.
- CONT=1 with no reads, 9 results: conv_start stops once full (count=8, STATUS bit9); the forced 9th result_valid sets OVF (0x608); W1C 0x400 clears OVF.
- Full FIFO, DATA read coincident with result_valid=0x3FF: count stays 8; OVF stays 0; the 0x3FF entry is read last.
- Assert wb_rst_i during WAIT and during a pending ack: no ack emitted, conv_start=0, STATUS reads 0x100 afterwards.
- With SAR_WB_READER_IRQ_EN defined and THRESH=3: irq rises the cycle after count reaches 3 and falls after a pop to 2.
